// File: rtl/seg14_scan_decoder_if.sv
// Display bus between a 14-segment scan driver (master) and its receivers (slave):
// one-hot digit select plus the segment pattern of the selected digit.
interface seg14_scan_decoder_if #(
    parameter int DIGITS = 12,
    parameter int SEG_W  = 14
);
    logic [DIGITS-1:0] sel;
    logic [SEG_W-1:0]  segm;

    modport master (output sel, output segm);
    modport slave  (input  sel, input  segm);
endinterface

// File: rtl/seg14_scan_decoder.sv
// Loopback monitor for the 12-digit 14-segment scan bus: validates scan order, decodes
// patterns to ASCII and commits whole frames. `define SEG_ERR_CNT_EN adds err_count.
module seg14_scan_decoder #(
    parameter int DIGITS = 12,
    parameter int SEG_W  = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg14_scan_decoder_if.slave  bus,
    input  logic [3:0]           rd_addr,
    output logic [7:0]           rd_data,
    output logic                 frame_done,
    output logic                 frame_valid,
    output logic                 frame_stable,
    output logic                 sel_err
`ifdef SEG_ERR_CNT_EN
    ,
    output logic [7:0]           err_count
`endif
);

    localparam logic [7:0] SPACE = 8'h20;

    typedef enum logic [1:0] {SYNC, CAPT, COMMIT} state_t;

    function automatic logic [7:0] decode_char(input logic [SEG_W-1:0] p);
        case (p)
            14'b11101111000000: return 8'h41; // A
            14'b11110001010010: return 8'h42; // B
            14'b10011100000000: return 8'h43; // C
            14'b11110000010010: return 8'h44; // D
            14'b10011110000000: return 8'h45; // E
            14'b10001110000000: return 8'h46; // F
            14'b10111101000000: return 8'h47; // G
            14'b01101111000000: return 8'h48; // H
            14'b00011100000000: return 8'h4C; // L
            14'b01101100100100: return 8'h4E; // N
            14'b11111100000000: return 8'h4F; // O
            14'b11001111000000: return 8'h50; // P
            14'b10110111000000: return 8'h53; // S
            14'b10000000010010: return 8'h54; // T
            14'b01111100000000: return 8'h55; // U
            14'b00000000000000: return SPACE;
            default:            return 8'h3F; // ?
        endcase
    endfunction

    state_t              state_q, state_d;
    logic [DIGITS-1:0]   sel_q, sel_d;
    logic [SEG_W-1:0]    segm_q, segm_d;
    logic [3:0]          expect_q, expect_d;
    logic [3:0]          last_idx_q, last_idx_d;
    logic [7:0]          shadow_q [DIGITS];
    logic [7:0]          shadow_d [DIGITS];
    logic [7:0]          committed_q [DIGITS];
    logic [7:0]          committed_d [DIGITS];
    logic [7:0]          rd_data_q, rd_data_d;
    logic                frame_done_q, frame_done_d;
    logic                frame_valid_q, frame_valid_d;
    logic                frame_stable_q, frame_stable_d;
    logic                sel_err_q, sel_err_d;

    logic [3:0]          idx;
    logic [3:0]          ones;
    logic                sel_ok;
    logic                is_first;
    logic [7:0]          char_now;
    logic                same_frame;
    logic                start_frame;
    logic                write_idx;
    logic                bad_sample;

    // Index of the registered select; a zero or multi-hot select is rejected via ones.
    always_comb begin
        idx  = '0;
        ones = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel_q[i]) begin
                idx  = 4'(i);
                ones = ones + 4'd1;
            end
        end
        sel_ok     = (ones == 4'd1);
        is_first   = (sel_q == DIGITS'(1));
        char_now   = decode_char(segm_q);
        same_frame = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (shadow_q[i] != committed_q[i]) same_frame = 1'b0;
        end
    end

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through this block can infer a latch.
        sel_d          = bus.sel;
        segm_d         = bus.segm;
        state_d        = state_q;
        expect_d       = expect_q;
        last_idx_d     = last_idx_q;
        shadow_d       = shadow_q;
        committed_d    = committed_q;
        frame_done_d   = 1'b0;
        frame_valid_d  = frame_valid_q;
        frame_stable_d = frame_stable_q;
        sel_err_d      = 1'b0;
        start_frame    = 1'b0;
        write_idx      = 1'b0;
        bad_sample     = 1'b0;

        unique case (state_q)
            SYNC: start_frame = is_first;
            CAPT: begin
                if (!sel_ok) begin
                    bad_sample = 1'b1;
                end else if (idx == last_idx_q) begin
                    write_idx = 1'b1;
                end else if (idx == expect_q) begin
                    write_idx  = 1'b1;
                    expect_d   = expect_q + 4'd1;
                    last_idx_d = idx;
                    if (idx == 4'(DIGITS - 1)) state_d = COMMIT;
                end else begin
                    bad_sample = 1'b1;
                end
            end
            COMMIT: begin
                committed_d    = shadow_q;
                frame_done_d   = 1'b1;
                frame_valid_d  = 1'b1;
                frame_stable_d = same_frame && frame_valid_q;
                state_d        = SYNC;
                start_frame    = is_first;
            end
            default: state_d = SYNC;
        endcase

        if (bad_sample) begin
            sel_err_d = 1'b1;
            state_d   = SYNC;
            for (int i = 0; i < DIGITS; i++) shadow_d[i] = SPACE;
            start_frame = is_first;
        end

        if (write_idx) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (idx == 4'(i)) shadow_d[i] = char_now;
            end
        end

        // A select of bit 0 always opens a frame, also right after a commit or a rejected sample.
        if (start_frame) begin
            shadow_d[0] = char_now;
            expect_d    = 4'd1;
            last_idx_d  = 4'd0;
            state_d     = (DIGITS == 1) ? COMMIT : CAPT;
        end

        rd_data_d = 8'h00;
        for (int i = 0; i < DIGITS; i++) begin
            if (rd_addr == 4'(i)) rd_data_d = committed_q[i];
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= SYNC;
            sel_q          <= '0;
            segm_q         <= '0;
            expect_q       <= '0;
            last_idx_q     <= '0;
            rd_data_q      <= 8'h00;
            frame_done_q   <= 1'b0;
            frame_valid_q  <= 1'b0;
            frame_stable_q <= 1'b0;
            sel_err_q      <= 1'b0;
            // NOTE: both buffers are small register arrays and must read back as spaces after reset, so they are reset here.
            for (int i = 0; i < DIGITS; i++) begin
                shadow_q[i]    <= SPACE;
                committed_q[i] <= SPACE;
            end
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            segm_q         <= segm_d;
            expect_q       <= expect_d;
            last_idx_q     <= last_idx_d;
            rd_data_q      <= rd_data_d;
            frame_done_q   <= frame_done_d;
            frame_valid_q  <= frame_valid_d;
            frame_stable_q <= frame_stable_d;
            sel_err_q      <= sel_err_d;
            shadow_q       <= shadow_d;
            committed_q    <= committed_d;
        end
    end

    assign rd_data      = rd_data_q;
    assign frame_done   = frame_done_q;
    assign frame_valid  = frame_valid_q;
    assign frame_stable = frame_stable_q;
    assign sel_err      = sel_err_q;

`ifdef SEG_ERR_CNT_EN
    logic [7:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (sel_err_d && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_count_q <= 8'h00;
        else        err_count_q <= err_count_d;
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_seg14_scan_decoder.sv
// Scoreboard bench for seg14_scan_decoder: frame and error expectations are queued by the
// stimulus and retired by an independent monitor that also sweeps the read port.
module tb_seg14_scan_decoder;

    localparam int DIGITS = 12;
    localparam int SEG_W  = 14;

    localparam logic [13:0] PAT [16] = '{
        14'b11101111000000, 14'b11110001010010, 14'b10011100000000, 14'b11110000010010,
        14'b10011110000000, 14'b10001110000000, 14'b10111101000000, 14'b01101111000000,
        14'b00011100000000, 14'b01101100100100, 14'b11111100000000, 14'b11001111000000,
        14'b10110111000000, 14'b10000000010010, 14'b01111100000000, 14'b00000000000000};
    localparam logic [7:0] ASC [16] = '{
        8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48,
        8'h4C, 8'h4E, 8'h4F, 8'h50, 8'h53, 8'h54, 8'h55, 8'h20};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg14_scan_decoder_if #(.DIGITS(DIGITS), .SEG_W(SEG_W)) bus ();
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       frame_done, frame_valid, frame_stable, sel_err;
`ifdef SEG_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    seg14_scan_decoder #(.DIGITS(DIGITS), .SEG_W(SEG_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .frame_done   (frame_done),
        .frame_valid  (frame_valid),
        .frame_stable (frame_stable),
        .sel_err      (sel_err)
`ifdef SEG_ERR_CNT_EN
        ,
        .err_count    (err_count)
`endif
    );

    typedef struct {int cyc; bit stable; logic [95:0] text;} frame_exp_t;
    typedef struct {int cyc; int cnt;} err_exp_t;

    frame_exp_t   fq[$];
    err_exp_t     eq[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc = 0;
    logic [95:0]  model_last;
    bit           model_valid;
    int           model_errs;
    logic [167:0] last_pats;
    bit           mon_en = 1'b0;
    logic [95:0]  cur_text = {12{8'h20}};
    bit           rd_pend = 1'b0;
    logic [7:0]   rd_exp;
    int           sweep_k = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ref_decode(input logic [13:0] p);
        for (int i = 0; i < 16; i++) if (PAT[i] == p) return ASC[i];
        return 8'h3F;
    endfunction

    function automatic logic [167:0] enc_text(input string s);
        logic [167:0] r = '0;
        for (int d = 0; d < DIGITS; d++)
            for (int i = 0; i < 16; i++)
                if (ASC[i] == s[d]) r[d*14 +: 14] = PAT[i];
        return r;
    endfunction

    function automatic logic [13:0] rand_pat();
        if ($urandom_range(0, 7) == 0) return 14'($urandom);
        return PAT[$urandom_range(0, 15)];
    endfunction

    function automatic logic [167:0] rand_frame();
        logic [167:0] r;
        for (int d = 0; d < DIGITS; d++) r[d*14 +: 14] = rand_pat();
        return r;
    endfunction

    task automatic drive(input logic [11:0] s, input logic [13:0] p, output int n);
        @(negedge clk);
        bus.sel  = s;
        bus.segm = p;
        n = cyc + 1;
    endtask

    task automatic push_err(input int n);
        err_exp_t e;
        model_errs++;
        e.cyc = n + 1;
        e.cnt = (model_errs > 255) ? 255 : model_errs;
        eq.push_back(e);
    endtask

    task automatic idle(input int cycles);
        int n;
        for (int g = 0; g < cycles; g++) drive(12'h000, 14'($urandom), n);
    endtask

    task automatic send_frame(input logic [167:0] pats, input int dwell, input bit first_err, input int gap);
        int n;
        logic [95:0] txt;
        frame_exp_t f;
        for (int d = 0; d < DIGITS; d++) txt[d*8 +: 8] = ref_decode(pats[d*14 +: 14]);
        for (int d = 0; d < DIGITS; d++) begin
            for (int r = 0; r < dwell; r++) begin
                drive(12'(1) << d, pats[d*14 +: 14], n);
                if (d == 0 && r == 0 && first_err) push_err(n);
                if (d == DIGITS - 1 && r == 0) begin
                    f.cyc    = n + 2;
                    f.stable = model_valid && (txt == model_last);
                    f.text   = txt;
                    fq.push_back(f);
                    model_last  = txt;
                    model_valid = 1'b1;
                end
            end
        end
        last_pats = pats;
        idle(gap);
    endtask

    task automatic send_prefix(input int k);
        int n;
        for (int d = 0; d < k; d++) drive(12'(1) << d, rand_pat(), n);
    endtask

    // kind 0: out-of-order index, 1: no select, 2: two selects at once
    task automatic send_error(input int k, input int kind);
        int n;
        int b;
        int b2;
        logic [11:0] s;
        send_prefix(k);
        case (kind)
            0: begin
                b = $urandom_range(1, 11);
                while (b == k - 1 || b == k) b = $urandom_range(1, 11);
                s = 12'(1) << b;
            end
            1: s = 12'h000;
            default: begin
                b  = $urandom_range(0, 11);
                b2 = (b + 1 + $urandom_range(0, 10)) % 12;
                s  = (12'(1) << b) | (12'(1) << b2);
            end
        endcase
        drive(s, rand_pat(), n);
        push_err(n);
    endtask

    // Monitor: retires queued expectations when the DUT pulses, and keeps the read port busy.
    initial begin : monitor
        int a;
        frame_exp_t f;
        err_exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (rd_pend) check("rd_data", 96'(rd_data), 96'(rd_exp));
                while (eq.size() > 0 && eq[0].cyc < cyc) begin
                    e = eq.pop_front();
                    n_checks++; n_errors++;
                    $display("FAIL sel_err missing: pulse due at cycle %0d not seen by %0d", e.cyc, cyc);
                end
                while (fq.size() > 0 && fq[0].cyc < cyc) begin
                    f = fq.pop_front();
                    n_checks++; n_errors++;
                    $display("FAIL frame_done missing: pulse due at cycle %0d not seen by %0d", f.cyc, cyc);
                end
                if (sel_err) begin
                    if (eq.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL sel_err unexpected: pulse at cycle %0d", cyc);
                    end else begin
                        e = eq.pop_front();
                        check("sel_err_cycle", 96'(cyc), 96'(e.cyc));
`ifdef SEG_ERR_CNT_EN
                        check("err_count", 96'(err_count), 96'(e.cnt));
`endif
                    end
                end
                if (frame_done) begin
                    if (fq.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL frame_done unexpected: pulse at cycle %0d", cyc);
                    end else begin
                        f = fq.pop_front();
                        check("frame_done_cycle", 96'(cyc), 96'(f.cyc));
                        check("frame_stable", 96'(frame_stable), 96'(f.stable));
                        check("frame_valid", 96'(frame_valid), 96'(1));
                        cur_text = f.text;
                        sweep_k  = 0;
                    end
                end
                if (sweep_k >= 0) begin
                    rd_addr = 4'(sweep_k);
                    rd_exp  = cur_text[sweep_k*8 +: 8];
                    sweep_k = (sweep_k == DIGITS - 1) ? -1 : sweep_k + 1;
                end else begin
                    a = $urandom_range(0, 15);
                    rd_addr = 4'(a);
                    rd_exp  = (a < DIGITS) ? cur_text[a*8 +: 8] : 8'h00;
                end
                rd_pend = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [167:0] pablo;
        logic [167:0] p;
        int n;
        int kind;
        bus.sel = '0;
        bus.segm = '0;
        rd_addr = '0;
        model_valid = 1'b0;
        model_errs = 0;
        model_last = '0;

        repeat (3) @(negedge clk);
        check("reset frame_done", 96'(frame_done), 96'(0));
        check("reset frame_valid", 96'(frame_valid), 96'(0));
        check("reset frame_stable", 96'(frame_stable), 96'(0));
        check("reset sel_err", 96'(sel_err), 96'(0));
        check("reset rd_data", 96'(rd_data), 96'(0));
`ifdef SEG_ERR_CNT_EN
        check("reset err_count", 96'(err_count), 96'(0));
`endif
        rst_n = 1'b1;
        mon_en = 1'b1;

        pablo = enc_text("PABLO GON EN");
        repeat (3) send_frame(pablo, 1, 1'b0, 0);
        idle(2);

        // Skip digit 4, then a clean frame; committed contents must survive the aborted one.
        send_prefix(4);
        drive(12'h020, rand_pat(), n);
        push_err(n);
        idle(14);
        send_frame(pablo, 1, 1'b0, 1);

        send_prefix(2);
        drive(12'h003, rand_pat(), n);
        push_err(n);
        idle(2);
        send_prefix(3);
        drive(12'h000, rand_pat(), n);
        push_err(n);
        idle(2);

        p = pablo;
        p[3*14 +: 14] = 14'b11111111000000;
        send_frame(p, 3, 1'b0, 0);
        send_frame(p, 3, 1'b0, 2);

        send_prefix(5);
        send_frame(rand_frame(), 1, 1'b1, 1);

        repeat (60) begin
            kind = $urandom_range(0, 9);
            if (kind < 5) begin
                p = ($urandom_range(0, 2) == 0) ? last_pats : rand_frame();
                send_frame(p, $urandom_range(1, 2), 1'b0, $urandom_range(0, 3));
            end else if (kind < 7) begin
                send_prefix($urandom_range(2, 11));
                send_frame(rand_frame(), 1, 1'b1, $urandom_range(0, 2));
            end else begin
                send_error($urandom_range(1, 11), $urandom_range(0, 2));
                idle($urandom_range(0, 2));
            end
        end

        repeat (300) begin
            drive(12'h001, rand_pat(), n);
            drive(12'h000, rand_pat(), n);
            push_err(n);
        end
        idle(4);
`ifdef SEG_ERR_CNT_EN
        check("err_count saturated", 96'(err_count), 96'(255));
`endif

        send_prefix(5);
        @(negedge clk);
        mon_en = 1'b0;
        bus.sel = '0;
        #2 rst_n = 1'b0;
        #1;
        check("async reset frame_done", 96'(frame_done), 96'(0));
        check("async reset frame_valid", 96'(frame_valid), 96'(0));
        check("async reset frame_stable", 96'(frame_stable), 96'(0));
        check("async reset sel_err", 96'(sel_err), 96'(0));
        check("async reset rd_data", 96'(rd_data), 96'(0));
`ifdef SEG_ERR_CNT_EN
        check("async reset err_count", 96'(err_count), 96'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;
        rd_addr = 4'd0;
        #1 check("rd_data after release", 96'(rd_data), 96'(0));
        @(negedge clk);
        check("rd_data space after reset", 96'(rd_data), 96'(8'h20));

        fq.delete();
        eq.delete();
        model_valid = 1'b0;
        model_errs = 0;
        cur_text = {12{8'h20}};
        rd_pend = 1'b0;
        sweep_k = -1;
        mon_en = 1'b1;

        send_frame(pablo, 1, 1'b0, 2);
        send_error(3, 1);
        idle(20);
        check("frame queue drained", 96'(fq.size()), 96'(0));
        check("error queue drained", 96'(eq.size()), 96'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
